rr_token_arbiter: RTL and testbench

RR_TOKEN_ARBITER -- requirements
Module: rr_token_arbiter

---
 rtl/rr_token_arbiter.sv | 122 ++++++++++++
 tb/tb_rr_token_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_token_arbiter.sv
// Round-robin token arbiter with four-phase req/ack handshake.
// A token walks over the clients; the holder is granted while it keeps req high.
// SKIP selects strict rotation (0) or jumping straight to the next requester (1).
// HOLD_MAX > 0 enables a watchdog that revokes over-long grants and masks the
// offending client until it drops its request.
module rr_token_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned SKIP     = 0,
    parameter int unsigned HOLD_MAX = 0,
    parameter int unsigned SW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  ack,
    output logic [SW-1:0] sel,
    output logic          active,
    output logic          timeout
);

    // Counter only needs to reach HOLD_MAX-1; it saturates otherwise.
    localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic {StIdle, StGrant} state_e;

    state_e          state;
    logic [SW-1:0]   tok;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    mask;

    logic [N-1:0]    elig;
    logic [SW-1:0]   tok_inc;
    logic [N-1:0]    tok_oh;
    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic [SW-1:0]   idx;
    logic            grant_ok;
    logic [SW-1:0]   grant_idx;
    logic [N-1:0]    grant_oh;
    logic            wd_fire;

    assign elig    = req & ~mask;
    assign tok_inc = (tok == SW'(N - 1)) ? '0 : tok + 1'b1;
    assign tok_oh  = N'(1) << tok;
    assign wd_fire = (HOLD_MAX != 0) && (cnt == CW'(HOLD_MAX - 1));

    // Find the first eligible requester at or after the token, wrapping to 0.
    always_comb begin
        hit     = 1'b0;
        hit_idx = tok;
        idx     = tok;
        for (int k = 0; k < int'(N); k++) begin
            idx = SW'((32'(tok) + 32'(k)) % N);
            if (!hit && elig[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    // Choose who would be granted from IDLE this cycle.
    always_comb begin
        if (SKIP != 0) begin
            grant_ok  = hit;
            grant_idx = hit_idx;
        end else begin
            grant_ok  = elig[tok];
            grant_idx = tok;
        end
        grant_oh = N'(1) << grant_idx;
    end

    // Arbitration FSM: token, grant, hold counter, revoke mask and pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            tok     <= '0;
            cnt     <= '0;
            mask    <= '0;
            ack     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            // A masked client is released from the mask once it drops req.
            mask    <= mask & req;
            unique case (state)
                StIdle: begin
                    if (grant_ok) begin
                        tok   <= grant_idx;
                        ack   <= grant_oh;
                        cnt   <= '0;
                        state <= StGrant;
                    end else if (SKIP == 0) begin
                        tok <= tok_inc;
                    end
                end
                StGrant: begin
                    if (!req[tok]) begin
                        // Normal release wins over a watchdog firing on the same edge.
                        ack   <= '0;
                        tok   <= tok_inc;
                        state <= StIdle;
                    end else if (wd_fire) begin
                        ack     <= '0;
                        mask    <= (mask & req) | tok_oh;
                        timeout <= 1'b1;
                        tok     <= tok_inc;
                        state   <= StIdle;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign sel    = tok;
    // Derived from the registered ack only; no path from req.
    assign active = |ack;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// Bench for rr_token_arbiter: three instances (strict+watchdog, skip, odd N)
// checked every cycle against a grant-level model, plus directed literals.
module tb_rr_token_arbiter;

    typedef struct {
        int          owner;   // granted client, -1 when none
        int          tok;
        int          held;    // cycles the current grant has had ack high
        logic [15:0] masked;
        logic        to;
    } mstate_t;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, ack_a;
    logic [1:0] sel_a;
    logic       active_a, timeout_a;
    logic [2:0] req_b, ack_b;
    logic [1:0] sel_b;
    logic       active_b, timeout_b;
    logic [4:0] req_c, ack_c;
    logic [2:0] sel_c;
    logic       active_c, timeout_c;

    int checks = 0;
    int failures = 0;
    mstate_t ma, mb, mc;

    rr_token_arbiter #(.N(4), .SKIP(0), .HOLD_MAX(5)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .ack(ack_a), .sel(sel_a),
        .active(active_a), .timeout(timeout_a)
    );
    rr_token_arbiter #(.N(3), .SKIP(1), .HOLD_MAX(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .ack(ack_b), .sel(sel_b),
        .active(active_b), .timeout(timeout_b)
    );
    rr_token_arbiter #(.N(5), .SKIP(0), .HOLD_MAX(0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .ack(ack_c), .sel(sel_c),
        .active(active_c), .timeout(timeout_c)
    );

    always #5 clk = ~clk;

    function automatic mstate_t m_reset();
        mstate_t x;
        x.owner = -1; x.tok = 0; x.held = 0; x.masked = '0; x.to = 1'b0;
        return x;
    endfunction

    // One clock edge of the arbiter, stated in terms of grants and tokens.
    function automatic mstate_t m_step(input mstate_t s, input logic [15:0] r, input int n,
                                       input int skip, input int hmax);
        mstate_t x;
        x = s;
        x.to = 1'b0;
        x.masked = s.masked & r;
        if (s.owner < 0) begin
            if (skip != 0) begin
                for (int k = 0; k < n; k++) begin
                    int j;
                    j = (s.tok + k) % n;
                    if (x.owner < 0 && r[j] && !s.masked[j]) begin
                        x.owner = j; x.tok = j; x.held = 1;
                    end
                end
            end else if (r[s.tok] && !s.masked[s.tok]) begin
                x.owner = s.tok; x.held = 1;
            end else begin
                x.tok = (s.tok + 1) % n;
            end
        end else if (!r[s.owner]) begin
            x.owner = -1; x.tok = (s.tok + 1) % n;
        end else if (hmax > 0 && s.held >= hmax) begin
            x.owner = -1; x.masked[s.owner] = 1'b1; x.to = 1'b1; x.tok = (s.tok + 1) % n;
        end else begin
            x.held = s.held + 1;
        end
        return x;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] ack, input logic [15:0] sel,
                       input logic act, input logic to, input mstate_t m);
        logic [15:0] ea;
        ea = (m.owner >= 0) ? (16'd1 << m.owner) : 16'd0;
        checks++;
        if (ack !== ea || sel !== 16'(m.tok) || act !== (m.owner >= 0) || to !== m.to ||
            !$onehot0(ack)) begin
            failures++;
            $display("FAIL %s t=%0t ack=%h want %h sel=%0d want %0d active=%b want %b timeout=%b want %b",
                     nm, $time, ack, ea, sel, m.tok, act, (m.owner >= 0), to, m.to);
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, got, exp);
        end
    endtask

    // Advance one clock: step the models on the edge, compare #2 later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma = m_reset(); mb = m_reset(); mc = m_reset();
        end else begin
            ma = m_step(ma, {12'b0, req_a}, 4, 0, 5);
            mb = m_step(mb, {13'b0, req_b}, 3, 1, 0);
            mc = m_step(mc, {11'b0, req_c}, 5, 0, 0);
        end
        #2;
        cmp("model_a", {12'b0, ack_a}, 16'(sel_a), active_a, timeout_a, ma);
        cmp("model_b", {13'b0, ack_b}, 16'(sel_b), active_b, timeout_b, mb);
        cmp("model_c", {11'b0, ack_c}, 16'(sel_c), active_c, timeout_c, mc);
    endtask

    initial begin
        int          hold_b[3];
        int          order[$];
        logic [2:0]  prev_b;
        int          exp_b[5];
        int          on_cnt;
        int          pulses;
        logic        got;

        clk = 1'b0; rst = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        ma = m_reset(); mb = m_reset(); mc = m_reset();
        #1 rst = 1'b1;
        req_a = 4'b0100;
        #1;
        chk("reset_ack", {12'b0, ack_a}, 16'h0);
        chk("reset_sel", 16'(sel_a), 16'h0);
        chk("reset_active", {15'b0, active_a}, 16'h0);
        chk("reset_timeout", {15'b0, timeout_a}, 16'h0);
        tick();
        tick();
        rst = 1'b0;

        // Strict walk to client 2, short grant, release; N=5 token wraps freely.
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) req_a = 4'b0000;
            tick();
            chk("c_rotate_sel", 16'(sel_c), 16'(k % 5));
            if (k <= 2) begin
                chk("a_walk_sel", 16'(sel_a), 16'(k));
                chk("a_walk_ack", {12'b0, ack_a}, 16'h0);
            end else if (k <= 5) begin
                chk("a_grant_ack", {12'b0, ack_a}, 16'h0004);
                chk("a_grant_sel", 16'(sel_a), 16'h2);
            end else begin
                chk("a_release_ack", {12'b0, ack_a}, 16'h0);
                chk("a_release_sel", 16'(sel_a), 16'h3);
            end
        end

        // SKIP=1, N=3: everyone requests, each drops req two cycles after its ack.
        exp_b = '{0, 1, 2, 0, 1};
        hold_b = '{0, 0, 0};
        prev_b = '0;
        req_b = 3'b111;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (ack_b != 3'b000 && ack_b != prev_b) begin
                for (int i = 0; i < 3; i++) if (ack_b[i]) order.push_back(i);
            end
            prev_b = ack_b;
            for (int i = 0; i < 3; i++) begin
                if (ack_b[i]) begin
                    hold_b[i]++;
                    if (hold_b[i] == 2) begin
                        req_b[i] = 1'b0;
                        hold_b[i] = 0;
                    end
                end else if (!req_b[i]) begin
                    req_b[i] = 1'b1;
                end
            end
        end
        req_b = '0;
        for (int i = 0; i < 5; i++)
            chk("b_grant_order", 16'((i < order.size()) ? order[i] : 15), 16'(exp_b[i]));

        // Watchdog: client 1 holds req forever, gets exactly 5 cycles, then is masked.
        req_a = 4'b0010;
        on_cnt = 0;
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (ack_a[1]) on_cnt++;
            if (timeout_a) pulses++;
        end
        chk("a_wd_ack_cycles", 16'(on_cnt), 16'd5);
        chk("a_wd_pulses", 16'(pulses), 16'd1);

        // Drop and re-raise clears the mask; client 1 must be served again.
        req_a = 4'b0000;
        tick();
        req_a = 4'b0010;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                tick();
                if (ack_a[1]) got = 1'b1;
            end
        end
        chk("a_regrant", {15'b0, got}, 16'h1);

        // Release on the watchdog-terminal edge: normal release, no timeout.
        for (int k = 0; k < 4; k++) tick();
        chk("a_hold_5th", {12'b0, ack_a}, 16'h0002);
        req_a = 4'b0000;
        tick();
        chk("a_tie_timeout", {15'b0, timeout_a}, 16'h0);
        chk("a_tie_ack", {12'b0, ack_a}, 16'h0);
        chk("a_tie_sel", 16'(sel_a), 16'h2);

        // Reset two cycles into a grant of client 0.
        req_a = 4'b0001;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                tick();
                if (ack_a[0]) got = 1'b1;
            end
        end
        chk("a_grant0", {15'b0, got}, 16'h1);
        tick();
        tick();
        rst = 1'b1;
        ma = m_reset(); mb = m_reset(); mc = m_reset();
        #1;
        chk("a_midreset_ack", {12'b0, ack_a}, 16'h0);
        chk("a_midreset_sel", 16'(sel_a), 16'h0);
        chk("a_midreset_active", {15'b0, active_a}, 16'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("a_post_reset_ack", {12'b0, ack_a}, 16'h0001);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
